// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM responder constants and lane write FSM encoding
package sram_pkg;

   localparam int SRAM_AW  = 21;
   localparam int SRAM_DW  = 16;
   localparam int WR_CNT_W = 16;

   typedef enum logic [1:0] {
      LANE_IDLE    = 2'd0,
      LANE_WR_HOLD = 2'd1,
      LANE_COMMIT  = 2'd2
   } lane_state_t;

endpackage

// File: rtl/sram_lane_wr.sv
// rtl/sram_lane_wr.sv - per-byte-lane write capture FSM (IDLE / WR_HOLD / COMMIT)
module sram_lane_wr
   import sram_pkg::*;
#(
   parameter int AW = SRAM_AW
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lane_we_n,
   input  logic [AW-1:0] addr_in,
   input  logic [7:0]    data_in,
   output logic          in_hold,
   output logic          commit,
   output logic [AW-1:0] commit_addr,
   output logic [7:0]    commit_data
);

   lane_state_t   state, state_nxt;
   logic          latch_en;
   logic [AW-1:0] addr_q;
   logic [7:0]    data_q;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= LANE_IDLE;
      else        state <= state_nxt;
   end

   // next state; every low-strobe sample refreshes the latched address/byte
   always_comb begin
      state_nxt = state;
      in_hold   = 1'b0;
      commit    = 1'b0;
      latch_en  = 1'b0;
      case (state)
         LANE_IDLE: begin
            if (!lane_we_n) begin
               state_nxt = LANE_WR_HOLD;
               latch_en  = 1'b1;
            end
         end
         LANE_WR_HOLD: begin
            in_hold = 1'b1;
            if (!lane_we_n) latch_en  = 1'b1;
            else            state_nxt = LANE_COMMIT;
         end
         LANE_COMMIT: begin
            commit = 1'b1;
            if (!lane_we_n) begin
               state_nxt = LANE_WR_HOLD;
               latch_en  = 1'b1;
            end else begin
               state_nxt = LANE_IDLE;
            end
         end
         default: state_nxt = LANE_IDLE;
      endcase
   end

   // capture address and byte while the strobe is held low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (latch_en) begin
         addr_q <= addr_in;
         data_q <= data_in;
      end
   end

   assign commit_addr = addr_q;
   assign commit_data = data_q;

endmodule

// File: rtl/sram_responder16b.sv
// rtl/sram_responder16b.sv - 16-bit async SRAM responder; optional SRAM_RESP_FAULT_EN read-bit fault injection
module sram_responder16b
   import sram_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int RD_REG = 0
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SRAM_AW-1:0]  sram_a,
   inout  wire  [SRAM_DW-1:0]  sram_d,
   input  logic [1:0]          sram_we_n,
   input  logic [1:0]          sram_rd_n,
`ifdef SRAM_RESP_FAULT_EN
   input  logic                fault_en,
   input  logic [SRAM_AW-1:0]  fault_addr,
   input  logic [3:0]          fault_bit,
`endif
   output logic [WR_CNT_W-1:0] wr_count,
   output logic                bus_conflict,
   output logic                addr_unstable
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0]         mem_lo [DEPTH];
   logic [7:0]         mem_hi [DEPTH];
   logic [ADDR_W-1:0]  rd_idx;
   logic               hold_lo, hold_hi, commit_lo, commit_hi, cen_lo, cen_hi;
   logic [ADDR_W-1:0]  cidx_lo, cidx_hi;
   logic [7:0]         cdata_lo, cdata_hi;
   logic [15:0]        rd_word, rd_data, rd_out;
   logic               drv_lo, drv_hi, drv_q;
   logic [SRAM_AW-1:0] a_q;

   assign rd_idx = sram_a[ADDR_W-1:0];

   sram_lane_wr #(.AW(ADDR_W)) u_lane_lo (
      .clk(clk), .rst_n(rst_n), .lane_we_n(sram_we_n[0]),
      .addr_in(rd_idx), .data_in(sram_d[7:0]),
      .in_hold(hold_lo), .commit(commit_lo),
      .commit_addr(cidx_lo), .commit_data(cdata_lo)
   );

   sram_lane_wr #(.AW(ADDR_W)) u_lane_hi (
      .clk(clk), .rst_n(rst_n), .lane_we_n(sram_we_n[1]),
      .addr_in(rd_idx), .data_in(sram_d[15:8]),
      .in_hold(hold_hi), .commit(commit_hi),
      .commit_addr(cidx_hi), .commit_data(cdata_hi)
   );

   // a commit coinciding with reset is dropped
   assign cen_lo = commit_lo & rst_n;
   assign cen_hi = commit_hi & rst_n;

   // byte-lane memory write; contents deliberately never reset
   always_ff @(posedge clk) begin
      if (cen_lo) mem_lo[cidx_lo] <= cdata_lo;
      if (cen_hi) mem_hi[cidx_hi] <= cdata_hi;
   end

   // read word with write-first bypass of a same-cycle commit
   always_comb begin
      rd_word = {mem_hi[rd_idx], mem_lo[rd_idx]};
      if (cen_lo && cidx_lo == rd_idx) rd_word[7:0]  = cdata_lo;
      if (cen_hi && cidx_hi == rd_idx) rd_word[15:8] = cdata_hi;
   end

   generate
      if (RD_REG != 0) begin : g_rd_reg
         logic [15:0] rd_q;
         // read data registered one clk after the address is sampled
         always_ff @(posedge clk) begin
            if (!rst_n) rd_q <= '0;
            else        rd_q <= rd_word;
         end
         assign rd_data = rd_q;
      end else begin : g_rd_async
         assign rd_data = rd_word;
      end
   endgenerate

`ifdef SRAM_RESP_FAULT_EN
   // stuck-at-0 on one read bit at the selected address
   always_comb begin
      rd_out = rd_data;
      if (fault_en && rd_idx == fault_addr[ADDR_W-1:0]) rd_out[fault_bit] = 1'b0;
   end
`else
   assign rd_out = rd_data;
`endif

   assign drv_lo = rst_n & (sram_we_n == 2'b11) & ~sram_rd_n[0];
   assign drv_hi = rst_n & (sram_we_n == 2'b11) & ~sram_rd_n[1];

   assign sram_d[7:0]  = drv_lo ? rd_out[7:0]  : 8'bz;
   assign sram_d[15:8] = drv_hi ? rd_out[15:8] : 8'bz;

   // sticky protocol flags and saturating committed-write counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_count      <= '0;
         bus_conflict  <= 1'b0;
         addr_unstable <= 1'b0;
         drv_q         <= 1'b0;
         a_q           <= '0;
      end else begin
         drv_q <= drv_lo | drv_hi;
         a_q   <= sram_a;
         if (drv_q && sram_we_n != 2'b11) bus_conflict <= 1'b1;
         if ((hold_lo || hold_hi) && sram_a != a_q) addr_unstable <= 1'b1;
         if ((cen_lo || cen_hi) && wr_count != '1) wr_count <= wr_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_responder16b.sv
// tb/tb_sram_responder16b.sv - self-checking bench for sram_responder16b (ADDR_W=4, async read)
module tb_sram_responder16b;

   localparam int AW = 4;
   localparam int N  = 1 << AW;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [20:0] sram_a;
   logic [1:0]  sram_we_n, sram_rd_n;
   logic [15:0] wr_count;
   logic        bus_conflict, addr_unstable;
   logic [15:0] d_drv;
   logic        d_oe;
   wire  [15:0] sram_d;
`ifdef SRAM_RESP_FAULT_EN
   logic        fault_en;
   logic [20:0] fault_addr;
   logic [3:0]  fault_bit;
`endif

   assign sram_d = d_oe ? d_drv : 16'bz;

   sram_responder16b #(.ADDR_W(AW), .RD_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .sram_a(sram_a), .sram_d(sram_d),
      .sram_we_n(sram_we_n), .sram_rd_n(sram_rd_n),
`ifdef SRAM_RESP_FAULT_EN
      .fault_en(fault_en), .fault_addr(fault_addr), .fault_bit(fault_bit),
`endif
      .wr_count(wr_count), .bus_conflict(bus_conflict), .addr_unstable(addr_unstable)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  m_lo [N];
   logic [7:0]  m_hi [N];
   int          exp_cnt = 0;

   typedef struct packed {
      logic [20:0] wa;
      logic [15:0] wd;
      logic [1:0]  we;
      logic [20:0] ra;
      logic [15:0] exp_rd;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [15:0] model_rd(input logic [20:0] a);
      return {m_hi[a[AW-1:0]], m_lo[a[AW-1:0]]};
   endfunction

   task automatic model_wr(input logic [20:0] a, input logic [15:0] d, input logic [1:0] we);
      if (!we[0]) m_lo[a[AW-1:0]] = d[7:0];
      if (!we[1]) m_hi[a[AW-1:0]] = d[15:8];
      if (exp_cnt < 65535) exp_cnt++;
   endtask

   task automatic do_write(input logic [20:0] a, input logic [15:0] d, input logic [1:0] we);
      sram_a = a; d_drv = d; d_oe = 1'b1; sram_we_n = we; sram_rd_n = 2'b11;
      step(); step();
      sram_we_n = 2'b11; d_oe = 1'b0;
      step(); step();
      model_wr(a, d, we);
   endtask

   task automatic do_read(input logic [20:0] a, output logic [15:0] v);
      sram_a = a; sram_we_n = 2'b11; sram_rd_n = 2'b00;
      #2;
      v = sram_d;
      sram_rd_n = 2'b11;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; sram_we_n = 2'b11; sram_rd_n = 2'b11; d_oe = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      exp_cnt = 0;
   endtask

   initial begin
      logic [15:0] v;
      logic [20:0] ra;
      logic [1:0]  we;
      int          r;

      rst_n = 1'b0; sram_a = '0; sram_we_n = 2'b11; sram_rd_n = 2'b11;
      d_drv = '0; d_oe = 1'b0;
`ifdef SRAM_RESP_FAULT_EN
      fault_en = 1'b0; fault_addr = '0; fault_bit = '0;
`endif
      step(); step(); step();
      rst_n = 1'b1;
      step();

      chk("reset_wr_count", wr_count, 0);
      chk("reset_bus_conflict", bus_conflict, 0);
      chk("reset_addr_unstable", addr_unstable, 0);

      vecs[0] = '{21'h0,      16'h7FFF, 2'b00, 21'h0,      16'h7FFF, 16'd1};
      vecs[1] = '{21'h3,      16'h5566, 2'b00, 21'h3,      16'h5566, 16'd2};
      vecs[2] = '{21'h3,      16'h12AB, 2'b10, 21'h3,      16'h55AB, 16'd3};
      vecs[3] = '{21'h3,      16'h99CD, 2'b01, 21'h3,      16'h99AB, 16'd4};
      vecs[4] = '{21'h10007,  16'hC3C3, 2'b00, 21'h7,      16'hC3C3, 16'd5};
      vecs[5] = '{21'h7,      16'h0000, 2'b00, 21'h1FFFF7, 16'h0000, 16'd6};
      for (int i = 0; i < 6; i++) begin
         do_write(vecs[i].wa, vecs[i].wd, vecs[i].we);
         do_read(vecs[i].ra, v);
         chk($sformatf("vec%0d_read", i), v, vecs[i].exp_rd);
         chk($sformatf("vec%0d_count", i), wr_count, vecs[i].exp_cnt);
      end

      // read during the commit cycle sees the new data
      do_write(21'h9, 16'h1111, 2'b00);
      sram_a = 21'h9; d_drv = 16'hA5A5; d_oe = 1'b1; sram_we_n = 2'b00;
      step(); step();
      sram_we_n = 2'b11; d_oe = 1'b0;
      step();
      sram_rd_n = 2'b00;
      #2;
      chk("write_first_read", sram_d, 16'hA5A5);
      sram_rd_n = 2'b11;
      step();
      model_wr(21'h9, 16'hA5A5, 2'b00);
      chk("write_first_count", wr_count, exp_cnt);

      // staggered lane release counts once per lane
      do_write(21'hA, 16'h0000, 2'b00);
      sram_a = 21'hA; d_drv = 16'hBEEF; d_oe = 1'b1; sram_we_n = 2'b00;
      step(); step();
      sram_we_n = 2'b01;
      step(); step();
      sram_we_n = 2'b11; d_oe = 1'b0;
      step(); step();
      model_wr(21'hA, 16'hBEEF, 2'b10);
      model_wr(21'hA, 16'hBEEF, 2'b01);
      chk("stagger_count", wr_count, exp_cnt);
      do_read(21'hA, v);
      chk("stagger_read", v, 16'hBEEF);

      // full sweep: write 7FFF, read-add-one, check 8000
      for (int i = 0; i < N; i++) do_write(21'(i), 16'h7FFF, 2'b00);
      for (int i = 0; i < N; i++) begin
         do_read(21'(i), v);
         do_write(21'(i), v + 16'd1, 2'b00);
      end
      for (int i = 0; i < N; i++) begin
         do_read(21'(i), v);
         chk($sformatf("sweep_rd%0d", i), v, 16'h8000);
      end
      chk("sweep_bus_conflict", bus_conflict, 0);
      chk("sweep_addr_unstable", addr_unstable, 0);

      // randomized traffic against the array model
      for (int k = 0; k < 300; k++) begin
         ra = 21'($urandom);
         if ($urandom_range(0, 2) != 0) begin
            r  = $urandom_range(0, 2);
            we = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
            do_write(ra, 16'($urandom), we);
         end else begin
            do_read(ra, v);
            chk("rnd_read", v, model_rd(ra));
         end
      end
      chk("rnd_count", wr_count, exp_cnt);
      chk("rnd_bus_conflict", bus_conflict, 0);
      chk("rnd_addr_unstable", addr_unstable, 0);

      // reset in WR_HOLD aborts the write
      sram_a = 21'h5; d_drv = 16'hBEEF; d_oe = 1'b1; sram_we_n = 2'b00;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; sram_we_n = 2'b11; d_oe = 1'b0;
      step(); step(); step();
      exp_cnt = 0;
      chk("abort_count", wr_count, 0);
      do_read(21'h5, v);
      chk("abort_mem5", v, model_rd(21'h5));

      // read drive followed by write strobe -> bus_conflict, sticky
      sram_a = 21'h2; sram_rd_n = 2'b00; sram_we_n = 2'b11;
      step();
      sram_rd_n = 2'b11; d_drv = 16'h1234; d_oe = 1'b1; sram_we_n = 2'b00;
      step();
      chk("conflict_set", bus_conflict, 1);
      sram_we_n = 2'b11; d_oe = 1'b0;
      step(); step(); step();
      model_wr(21'h2, 16'h1234, 2'b00);
      chk("conflict_sticky", bus_conflict, 1);
      chk("unstable_before", addr_unstable, 0);

      // address moves during WR_HOLD -> addr_unstable
      sram_a = 21'h4; d_drv = 16'h4444; d_oe = 1'b1; sram_we_n = 2'b00;
      step();
      sram_a = 21'h6;
      step();
      chk("unstable_set", addr_unstable, 1);
      sram_we_n = 2'b11; d_oe = 1'b0;
      step(); step(); step();
      chk("unstable_sticky", addr_unstable, 1);
      chk("conflict_still", bus_conflict, 1);

      do_reset();
      chk("final_bus_conflict", bus_conflict, 0);
      chk("final_addr_unstable", addr_unstable, 0);
      chk("final_wr_count", wr_count, 0);

`ifdef SRAM_RESP_FAULT_EN
      do_write(21'h3, 16'h8000, 2'b00);
      fault_en = 1'b1; fault_addr = 21'h3; fault_bit = 4'd15;
      do_read(21'h3, v);
      chk("fault_on", v, 16'h0000);
      fault_en = 1'b0;
      do_read(21'h3, v);
      chk("fault_off", v, 16'h8000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_responder16b.md
SRAM_RESPONDER16B -- requirements
Module: sram_responder16b

Interface
REQ-001 Parameter ADDR_W, default 16, number of low sram_a bits decoded; emulated depth is 2**ADDR_W words.
REQ-002 Parameter RD_REG, default 0: 0 = asynchronous read path, 1 = read data registered one clk after address.
REQ-003 clk  in  1  single clock, shared with the SRAM initiator.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 sram_a  in  21  word address from initiator.
REQ-006 sram_d  inout  16  data bus; driven only on read, else high-Z.
REQ-007 sram_we_n  in  2  per-byte write strobes, active-low; [0]=d[7:0], [1]=d[15:8].
REQ-008 sram_rd_n  in  2  per-byte output enables, active-low.
REQ-009 wr_count  out  16  committed write transactions, saturating at FFFF.
REQ-010 bus_conflict  out  1  sticky: write strobe low in a cycle the responder drives sram_d.
REQ-011 addr_unstable  out  1  sticky: sram_a changed while any we_n lane low.

Function
REQ-012 Per-lane FSM, states IDLE, WR_HOLD, COMMIT; IDLE->WR_HOLD when the sampled we_n lane is 0.
REQ-013 WR_HOLD latches sram_a and the lane's data byte every cycle the lane stays low; the last low cycle's values win.
REQ-014 WR_HOLD->COMMIT on first sample of the lane high; COMMIT writes the latched byte to mem[latched_a[ADDR_W-1:0]] and returns to IDLE.
REQ-015 Both lanes rising on the same clk produce one 16-bit write and increment wr_count by 1; staggered lane releases count 1 per lane.
REQ-016 Address bits above ADDR_W-1 are ignored (aliasing); no error is raised.
REQ-017 Read drive enable = (sram_we_n == 2'b11) and lane rd_n low, per byte lane; lanes with rd_n high stay high-Z.
REQ-018 RD_REG=0: read data = mem[sram_a] combinationally, valid within the same clk as the address change.
REQ-019 RD_REG=1: read data valid on the clk after sram_a is sampled.
REQ-020 Read of a location being committed in the same clk returns the new data (write-first).
REQ-021 bus_conflict sets when any we_n lane is low while the drive enable of REQ-017 was asserted the previous clk; clears only on reset.
REQ-022 addr_unstable sets when sram_a differs from the previous clk's value while any lane is in WR_HOLD; clears only on reset.
REQ-023 Memory content is never reset; power-up contents are undefined (X in simulation).

Reset
REQ-024 rst_n low at a clk edge: lane FSMs -> IDLE, wr_count=0, bus_conflict=0, addr_unstable=0, read register=0.
REQ-025 Reset during WR_HOLD aborts the write; no commit occurs on the subsequent we_n rise.
REQ-026 During reset sram_d remains high-Z regardless of rd_n.

Configuration
REQ-027 Macro SRAM_RESP_FAULT_EN compiled in: extra inputs fault_en (1), fault_addr (21), fault_bit (4) force read bit fault_bit to 0 when fault_en=1 and sram_a[ADDR_W-1:0] == fault_addr[ADDR_W-1:0].
REQ-028 Without SRAM_RESP_FAULT_EN those ports do not exist and read data is unmodified.

Structure
REQ-029 Shared package sram_pkg holds lane FSM state encoding, SRAM_AW=21, SRAM_DW=16, and the wr_count width.
REQ-030 One sub-module sram_lane_wr (one instance per byte lane) implements REQ-012..REQ-014; the top owns memory, read path, flags and counter.

Verification
REQ-031 Write 16'h7FFF to addr 0 with we_n=00 held two clks, then read with rd_n=00 -> sram_d=7FFF, wr_count=1.
REQ-032 Initiator sweeps addresses 0..2**ADDR_W-1 writing 7FFF, read-add-one writes, then check pass -> every read returns 8000, both flags 0.
REQ-033 we_n=10 (low byte only) writes 12AB over 5566 -> readback 55AB, wr_count increments by 1.
REQ-034 rst_n low during WR_HOLD of write 0xBEEF to addr 5, then we_n rises -> mem[5] unchanged, wr_count=0.
REQ-035 rd_n=00, we_n=11 for 1 clk, then we_n=00 -> bus_conflict=1 and stays 1 until reset; sram_a changed during WR_HOLD -> addr_unstable=1.
REQ-036 With SRAM_RESP_FAULT_EN: fault_en=1, fault_addr=3, fault_bit=15, mem[3]=8000 -> read returns 0000; fault_en=0 -> 8000.
